// File: rtl/lamp_pkg.sv
// lamp_pkg: definitions shared by the lamp controller and the lamp sequencer.
//   lamp_state_e       - lamp state codes reported on Cur_State / requested on Target
//   seq_state_e        - lamp_sequencer FSM states
//   DEFAULT_*          - default timing/budget constants
//   target_legal()     - true when a requested state code names a real lamp state
package lamp_pkg;

  typedef enum logic [2:0] {
    WHITE_OFF  = 3'd0,
    WHITE_ON   = 3'd1,
    SUN_OFF    = 3'd2,
    SUN_ON     = 3'd3,
    YELLOW_OFF = 3'd4,
    YELLOW_ON  = 3'd5
  } lamp_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CHECK,
    SEQ_WAIT
  } seq_state_e;

  // 100 ms at 50 MHz between key presses.
  localparam int unsigned DEFAULT_PULSE_GAP  = 5_000_000;
  localparam int unsigned DEFAULT_MAX_PULSES = 6;

  localparam logic [2:0] LAMP_STATE_MAX = YELLOW_ON;

  function automatic logic target_legal(input logic [2:0] code);
    return (code <= LAMP_STATE_MAX);
  endfunction

endpackage

// File: rtl/gap_timer.sv
// gap_timer: 32-bit up-counter timing the spacing between key pulses.
//   Sys_CLK  - clock
//   Sys_RST  - asynchronous active-low reset, clears the count
//   clear    - synchronous clear to 0 (has priority over enable)
//   enable   - count up by one this cycle
//   tc       - terminal count flag, high while the count equals PULSE_GAP-1
module gap_timer
  import lamp_pkg::*;
#(
  parameter int unsigned PULSE_GAP = DEFAULT_PULSE_GAP
) (
  input  logic Sys_CLK,
  input  logic Sys_RST,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [31:0] TC_VAL = 32'(PULSE_GAP - 1);

  logic [31:0] gap_cnt;

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      gap_cnt <= '0;
    end else if (clear) begin
      gap_cnt <= '0;
    end else if (enable) begin
      gap_cnt <= gap_cnt + 32'd1;
    end
  end

  assign tc = (gap_cnt == TC_VAL);

endmodule

// File: rtl/lamp_sequencer.sv
// lamp_sequencer: steps a lamp controller to a requested state by issuing
// spaced key pulses, re-checking the reported state before each pulse.
//   Sys_CLK   - clock, all state on its rising edge
//   Sys_RST   - asynchronous active-low reset
//   Req       - start request, honoured only when idle
//   Target    - requested lamp state code (0..5 legal)
//   Abort     - cancel an active request (also blocks a start when idle)
//   Cur_State - lamp state reported by the lamp controller
//   Key_Out   - one-cycle key pulse to the lamp controller
//   Busy      - high while a request is active
//   Done      - one-cycle pulse, target reached
//   Err       - one-cycle pulse, illegal target or pulse budget exhausted
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int unsigned PULSE_GAP  = DEFAULT_PULSE_GAP,
  parameter int unsigned MAX_PULSES = DEFAULT_MAX_PULSES
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic       Req,
  input  logic [2:0] Target,
  input  logic       Abort,
  input  logic [2:0] Cur_State,
  output logic       Key_Out,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_PULSES);

  seq_state_e state, state_nxt;
  logic [2:0] tgt, tgt_nxt;
  logic [3:0] pulse_cnt, pulse_cnt_nxt;
  logic       key_nxt, busy_nxt, done_nxt, err_nxt;
  logic       gap_clear, gap_en, gap_tc;

  gap_timer #(
    .PULSE_GAP(PULSE_GAP)
  ) u_gap_timer (
    .Sys_CLK (Sys_CLK),
    .Sys_RST (Sys_RST),
    .clear   (gap_clear),
    .enable  (gap_en),
    .tc      (gap_tc)
  );

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state     <= SEQ_IDLE;
      tgt       <= '0;
      pulse_cnt <= '0;
      Key_Out   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      Key_Out   <= key_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      Err       <= err_nxt;
    end
  end

  // Outputs are computed as next-cycle values here and registered above,
  // so every output changes exactly on the edge that makes the decision.
  always_comb begin
    state_nxt     = state;
    tgt_nxt       = tgt;
    pulse_cnt_nxt = pulse_cnt;
    key_nxt       = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    gap_clear     = 1'b0;
    gap_en        = 1'b0;

    case (state)
      SEQ_IDLE: begin
        if (Req && !Abort) begin
          if (target_legal(Target)) begin
            tgt_nxt       = Target;
            pulse_cnt_nxt = '0;
            busy_nxt      = 1'b1;
            state_nxt     = SEQ_CHECK;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      SEQ_CHECK: begin
        if (Abort) begin
          state_nxt = SEQ_IDLE;
        end else if (Cur_State == tgt) begin
          done_nxt  = 1'b1;
          state_nxt = SEQ_IDLE;
        end else if (pulse_cnt == MAX_CNT) begin
          err_nxt   = 1'b1;
          state_nxt = SEQ_IDLE;
        end else begin
          key_nxt       = 1'b1;
          busy_nxt      = 1'b1;
          pulse_cnt_nxt = pulse_cnt + 4'd1;
          gap_clear     = 1'b1;
          state_nxt     = SEQ_WAIT;
        end
      end

      SEQ_WAIT: begin
        if (Abort) begin
          state_nxt = SEQ_IDLE;
        end else begin
          busy_nxt = 1'b1;
          gap_en   = 1'b1;
          if (gap_tc) begin
            state_nxt = SEQ_CHECK;
          end
        end
      end

      default: begin
        state_nxt = SEQ_IDLE;
      end
    endcase
  end

endmodule
